// File: rtl/rx_stream_arbiter_pkg.sv
// Shared types and helpers for the RX stream arbiter: FSM state encoding and
// width helpers used by the interface, the arbiter and the top.
package rx_stream_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULL  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SHIFT = 2'd3
    } arb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index width that stays at least 1 bit for a single-entry range.
    function automatic int id_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rx_stream_arbiter_if.sv
// FIFO-side and SMI-side signals of the RX stream arbiter, named from the
// arbiter's point of view; master = arbiter, slave = FIFOs/consumer.
interface rx_stream_arbiter_if
    import rx_stream_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 32,
    parameter int OUT_W    = 8
);
    localparam int CH_W = id_w(NUM_CH);

    logic [NUM_CH-1:0]               i_ch_en;
    logic [NUM_CH-1:0]               i_fifo_empty;
    logic [NUM_CH-1:0]               i_fifo_full;
    logic [NUM_CH-1:0][SAMPLE_W-1:0] i_fifo_data;
    logic [NUM_CH-1:0]               o_fifo_pull;
    logic [OUT_W-1:0]                o_data;
    logic                            o_valid;
    logic                            i_ready;
    logic [CH_W-1:0]                 o_ch_id;
    logic                            o_sop;
    logic                            i_clear_flags;
    logic [NUM_CH-1:0]               o_ovf;

    modport master (
        input  i_ch_en, i_fifo_empty, i_fifo_full, i_fifo_data, i_ready, i_clear_flags,
        output o_fifo_pull, o_data, o_valid, o_ch_id, o_sop, o_ovf
    );

    modport slave (
        output i_ch_en, i_fifo_empty, i_fifo_full, i_fifo_data, i_ready, i_clear_flags,
        input  o_fifo_pull, o_data, o_valid, o_ch_id, o_sop, o_ovf
    );

endinterface

// File: rtl/rx_stream_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping, returned both one-hot and encoded.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [CH_W-1:0]   o_idx,
    output logic              o_any
);
    always_comb begin
        int k;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = (int'(i_ptr) + i) % NUM_CH;
            if (!o_any && i_req[k]) begin
                o_any    = 1'b1;
                o_gnt[k] = 1'b1;
                o_idx    = CH_W'(k);
            end
        end
    end
endmodule

// File: rtl/rx_stream_arbiter.sv
// N-channel RX FIFO readout: round-robin burst arbitration, MSB-first
// serialisation of each sample into OUT_W-bit words, sticky overflow flags.
module rx_stream_arbiter
    import rx_stream_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 32,
    parameter int OUT_W    = 8,
    parameter int BURST    = 4,
    parameter int RD_LAT   = 1
) (
    input  logic                i_sys_clk,
    input  logic                i_reset,
    rx_stream_arbiter_if.master bus
);
    localparam int CH_W  = id_w(NUM_CH);
    localparam int WORDS = SAMPLE_W / OUT_W;
    localparam int WD_W  = id_w(WORDS);
    localparam int BU_W  = clog2(BURST + 1);
    localparam int LAT_W = 2;

    arb_state_t          r_state, w_state_nx;
    logic [CH_W-1:0]     r_grant, w_grant_nx;
    logic [CH_W-1:0]     r_ptr, w_ptr_nx;
    logic [BU_W-1:0]     r_burst, w_burst_nx, w_burst_inc;
    logic [WD_W-1:0]     r_word, w_word_nx;
    logic [LAT_W-1:0]    r_lat, w_lat_nx;
    logic [SAMPLE_W-1:0] r_shreg, w_shreg_nx;
    logic [NUM_CH-1:0]   r_ovf;
    logic [NUM_CH-1:0]   w_pull, w_req, w_gnt;
    logic [CH_W-1:0]     w_idx, w_ptr_inc;
    logic                w_any;

    assign w_req       = bus.i_ch_en & ~bus.i_fifo_empty;
    assign w_burst_inc = r_burst + BU_W'(1);
    assign w_ptr_inc   = (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + CH_W'(1);

    rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_ptr_nx   = r_ptr;
        w_burst_nx = r_burst;
        w_word_nx  = r_word;
        w_lat_nx   = r_lat;
        w_shreg_nx = r_shreg;
        w_pull     = '0;
        case (r_state)
            ST_IDLE: if (w_any) begin
                w_grant_nx = w_idx;
                w_burst_nx = '0;
                w_state_nx = ST_PULL;
            end
            // Empty is rechecked here: the FIFO may have drained since the grant.
            ST_PULL: if (!bus.i_fifo_empty[r_grant]) begin
                w_pull[r_grant] = 1'b1;
                w_lat_nx        = '0;
                w_state_nx      = ST_WAIT;
            end else begin
                w_ptr_nx   = w_ptr_inc;
                w_state_nx = ST_IDLE;
            end
            ST_WAIT: if (r_lat == LAT_W'(RD_LAT - 1)) begin
                w_shreg_nx = bus.i_fifo_data[r_grant];
                w_word_nx  = '0;
                w_state_nx = ST_SHIFT;
            end else begin
                w_lat_nx = r_lat + LAT_W'(1);
            end
            ST_SHIFT: if (bus.i_ready) begin
                w_shreg_nx = r_shreg << OUT_W;
                if (r_word == WD_W'(WORDS - 1)) begin
                    w_burst_nx = w_burst_inc;
                    if (w_burst_inc < BU_W'(BURST) && bus.i_ch_en[r_grant] &&
                        !bus.i_fifo_empty[r_grant]) begin
                        w_state_nx = ST_PULL;
                    end else begin
                        w_ptr_nx   = w_ptr_inc;
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_word_nx = r_word + WD_W'(1);
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_burst <= '0;
            r_word  <= '0;
            r_lat   <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_ptr   <= w_ptr_nx;
            r_burst <= w_burst_nx;
            r_word  <= w_word_nx;
            r_lat   <= w_lat_nx;
            r_shreg <= w_shreg_nx;
        end
    end

    // Set term is ORed after the clear so a coincident full wins.
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) r_ovf <= '0;
        else         r_ovf <= (r_ovf & ~{NUM_CH{bus.i_clear_flags}}) |
                              (bus.i_fifo_full & bus.i_ch_en);
    end

    assign bus.o_fifo_pull = w_pull;
    assign bus.o_valid     = (r_state == ST_SHIFT);
    assign bus.o_data      = r_shreg[SAMPLE_W-1 -: OUT_W];
    assign bus.o_ch_id     = r_grant;
    assign bus.o_sop       = (r_state == ST_SHIFT) && (r_word == '0);
    assign bus.o_ovf       = r_ovf;

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Scoreboard bench for rx_stream_arbiter: queue-backed FIFO models, expected
// word queue filled by directed scenarios, monitor pops on every accepted word.
module tb_rx_stream_arbiter;
    import rx_stream_arbiter_pkg::*;

    localparam int NUM_CH = 2, SAMPLE_W = 32, OUT_W = 8, BURST = 4, RD_LAT = 1;

    typedef struct packed {
        logic [7:0] data;
        logic       ch;
        logic       sop;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_stream_arbiter_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W)) bus ();

    rx_stream_arbiter #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .BURST(BURST), .RD_LAT(RD_LAT)
    ) dut (
        .i_sys_clk (clk),
        .i_reset   (rst),
        .bus       (bus)
    );

    word_t       exp_q[$];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          tests = 0;
    int          fails = 0;
    int          pulls0 = 0, pulls1 = 0;
    bit          rand_ready = 1'b0;
    logic        ready_fixed = 1'b1;

    // FIFO models, ready driver and output monitor share one process.
    initial begin
        bit    stall_prev;
        word_t held, e;
        stall_prev = 1'b0;
        held = '0;
        bus.i_fifo_data = '0;
        forever begin
            @(posedge clk);
            if (bus.o_fifo_pull[0]) begin
                tests++;
                pulls0++;
                if (q0.size() == 0) begin
                    fails++;
                    $display("FAIL pull_empty_ch0: pulled while model FIFO empty");
                end else bus.i_fifo_data[0] <= q0.pop_front();
            end
            if (bus.o_fifo_pull[1]) begin
                tests++;
                pulls1++;
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL pull_empty_ch1: pulled while model FIFO empty");
                end else bus.i_fifo_data[1] <= q1.pop_front();
            end
            bus.i_fifo_empty[0] <= (q0.size() == 0);
            bus.i_fifo_empty[1] <= (q1.size() == 0);
            #1;
            bus.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    tests++;
                    if (!(bus.o_valid && bus.o_data == held.data &&
                          bus.o_ch_id == held.ch && bus.o_sop == held.sop)) begin
                        fails++;
                        $display("FAIL stall_hold: got v=%0b d=%02h ch=%0d sop=%0b want d=%02h ch=%0d sop=%0b",
                                 bus.o_valid, bus.o_data, bus.o_ch_id, bus.o_sop,
                                 held.data, held.ch, held.sop);
                    end
                end
                if (bus.o_valid && bus.i_ready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_word: got d=%02h ch=%0d, expected none",
                                 bus.o_data, bus.o_ch_id);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.o_data != e.data || bus.o_ch_id != e.ch || bus.o_sop != e.sop) begin
                            fails++;
                            $display("FAIL word: got d=%02h ch=%0d sop=%0b want d=%02h ch=%0d sop=%0b",
                                     bus.o_data, bus.o_ch_id, bus.o_sop, e.data, e.ch, e.sop);
                        end
                    end
                end
                stall_prev = bus.o_valid && !bus.i_ready;
                held = '{data: bus.o_data, ch: bus.o_ch_id[0], sop: bus.o_sop};
            end
        end
    end

    function automatic logic [31:0] samp(input int ch, input int i);
        return {8'(8'hA0 + ch * 16 + i), 8'h5A, 8'(i * 3), 8'(ch + 1)};
    endfunction

    task automatic expect_sample(input int ch, input logic [31:0] s);
        for (int w = 0; w < 4; w++)
            exp_q.push_back('{data: s[31 - 8*w -: 8], ch: 1'(ch), sop: (w == 0)});
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_ch_en = '0;
        bus.i_fifo_full = '0;
        bus.i_clear_flags = 1'b0;
        ready_fixed = 1'b1;
        rand_ready = 1'b0;
        q0.delete();
        q1.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {bus.o_valid, bus.o_sop, bus.o_ch_id, bus.o_ovf, bus.o_fifo_pull, bus.o_data},
              32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.o_valid) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (n >= 5000) begin
            fails++;
            $display("FAIL %s_timeout: %0d words left, want 0", name, exp_q.size());
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic two_ch_bursts(input string name);
        int p0, p1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(samp(0, i));
            q1.push_back(samp(1, i));
        end
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < 4; i++) expect_sample(c, samp(c, 4*b + i));
        p0 = pulls0;
        p1 = pulls1;
        bus.i_ch_en = 2'b11;
        drain(name);
        check({name, "_pulls0"}, pulls0 - p0, 8);
        check({name, "_pulls1"}, pulls1 - p1, 8);
    endtask

    initial begin
        int p0, p1, n;
        bus.i_ch_en = '0;
        bus.i_fifo_full = '0;
        bus.i_clear_flags = 1'b0;

        // Idle with all FIFOs empty: nothing moves.
        do_reset();
        bus.i_ch_en = 2'b11;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_quiet", {bus.o_valid, bus.o_fifo_pull}, 32'h0);
        end

        // Single sample, words MSB first.
        do_reset();
        q0.push_back(32'hA1B2C3D4);
        exp_q.push_back('{data: 8'hA1, ch: 1'b0, sop: 1'b1});
        exp_q.push_back('{data: 8'hB2, ch: 1'b0, sop: 1'b0});
        exp_q.push_back('{data: 8'hC3, ch: 1'b0, sop: 1'b0});
        exp_q.push_back('{data: 8'hD4, ch: 1'b0, sop: 1'b0});
        p0 = pulls0;
        p1 = pulls1;
        bus.i_ch_en = 2'b11;
        drain("single");
        check("single_pulls0", pulls0 - p0, 1);
        check("single_pulls1", pulls1 - p1, 0);

        two_ch_bursts("burst");
        rand_ready = 1'b1;
        two_ch_bursts("stall");

        // ch1 runs dry after two samples of its burst.
        do_reset();
        for (int i = 0; i < 5; i++) q0.push_back(samp(0, i));
        for (int i = 0; i < 2; i++) q1.push_back(samp(1, i));
        for (int i = 0; i < 4; i++) expect_sample(0, samp(0, i));
        for (int i = 0; i < 2; i++) expect_sample(1, samp(1, i));
        expect_sample(0, samp(0, 4));
        p0 = pulls0;
        p1 = pulls1;
        bus.i_ch_en = 2'b11;
        drain("short");
        check("short_pulls0", pulls0 - p0, 5);
        check("short_pulls1", pulls1 - p1, 2);

        // Overflow flags follow enable, set beats clear.
        do_reset();
        q1.push_back(32'h11223344);
        bus.i_ch_en = 2'b01;
        bus.i_fifo_full = 2'b10;
        repeat (50) @(negedge clk);
        check("ovf_disabled", bus.o_ovf, 2'b00);
        expect_sample(1, 32'h11223344);
        bus.i_ch_en = 2'b11;
        @(negedge clk);
        check("ovf_set", bus.o_ovf, 2'b10);
        bus.i_clear_flags = 1'b1;
        @(negedge clk);
        bus.i_clear_flags = 1'b0;
        check("ovf_set_wins", bus.o_ovf, 2'b10);
        bus.i_fifo_full = 2'b00;
        bus.i_clear_flags = 1'b1;
        @(negedge clk);
        bus.i_clear_flags = 1'b0;
        check("ovf_cleared", bus.o_ovf, 2'b00);
        drain("ovf");

        // Reset while a word is held in SHIFT.
        do_reset();
        ready_fixed = 1'b0;
        q0.push_back(32'hCAFEF00D);
        bus.i_ch_en = 2'b01;
        n = 0;
        while (!bus.o_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midshift_valid", bus.o_valid, 1'b1);
        check("midshift_first", {bus.o_data, bus.o_sop}, {8'hCA, 1'b1});
        #2 rst = 1'b1;
        #1 check("reset_midshift", {bus.o_valid, bus.o_fifo_pull}, 32'h0);
        exp_q.delete();
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
